// File: rtl/inport_pkg.sv
// Shared constants and the edge-match helper for the strobe-capture FIFO.
`timescale 1ns/100ps
package inport_pkg;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // True when the synchronized strobe transition matches the selected mode.
    function automatic logic edge_hit(input int mode, input logic cur, input logic prev);
        logic hit;
        case (mode)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = ~cur & prev;
            EDGE_BOTH: hit = cur ^ prev;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/inport_fifo_sync_chain.sv
// Multi-flop synchronizer bringing the asynchronous strobe into the clock domain.
`timescale 1ns/100ps
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic clear_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at bit 0; the oldest sample leaves at the top.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flops.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/inport_fifo.sv
// Strobe-captured input port: synchronizes an external strobe, pushes the
// external data on the selected edge and presents the FIFO head to the bus.
`timescale 1ns/100ps
module inport_fifo
    import inport_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 32,
    parameter int DATA_WIDTH_OUT = 32,
    parameter int DEPTH          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int EDGE_MODE      = EDGE_RISE
) (
    input  logic                       clock,
    input  logic                       clear_n,
    input  logic                       strobe,
    input  logic [DATA_WIDTH_IN-1:0]   External_Input,
    input  logic                       read_en,
    input  logic                       clr_ovf,
    output logic [DATA_WIDTH_OUT-1:0]  BusMuxIn,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic                     sync_out_s;
    logic                     edge_s;
    logic                     full_s;
    logic                     pop_s;
    logic                     push_s;
    logic                     drop_s;
    logic [DATA_WIDTH_IN-1:0] head_s;
    logic [DATA_WIDTH_OUT-1:0] head_ext_s;

    logic [DATA_WIDTH_IN-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH_IN-1:0] mem_d [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;
    logic                     prev_q, prev_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock   (clock),
        .clear_n (clear_n),
        .d       (strobe),
        .q       (sync_out_s)
    );

    // Edge detection, push/pop arbitration and next-state for storage and flags.
    always_comb begin
        edge_s   = edge_hit(EDGE_MODE, sync_out_s, prev_q);
        prev_d   = sync_out_s;
        full_s   = (count_q == CW'(DEPTH));
        pop_s    = read_en & valid_q;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_s   = edge_s & (~full_s | pop_s);
        drop_s   = edge_s & full_s & ~pop_s;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = External_Input;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        valid_d = (count_d != CW'(0));

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; reset discards queued data and any in-flight edge.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            prev_q   <= prev_d;
        end
    end

    assign head_s = mem_q[rd_ptr_q];

    if (DATA_WIDTH_OUT > DATA_WIDTH_IN) begin : g_zext
        assign head_ext_s = {{(DATA_WIDTH_OUT - DATA_WIDTH_IN){1'b0}}, head_s};
    end else begin : g_trunc
        assign head_ext_s = head_s[DATA_WIDTH_OUT-1:0];
    end

    // Bus data is forced to zero whenever nothing is queued.
    always_comb begin
        if (valid_q) begin
            BusMuxIn = head_ext_s;
        end else begin
            BusMuxIn = '0;
        end
    end

    assign valid    = valid_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_inport_fifo.sv
// Directed bench for inport_fifo: rise/both/fall capture, full/overflow
// handling, asynchronous reset and input/output width adaptation.
`timescale 1ns/100ps
module tb_inport_fifo;
    import inport_pkg::*;

    logic clock = 1'b0;
    logic clear_n;

    logic        strobe_a, read_a, clr_a;
    logic [31:0] data_a, bus_a;
    logic        valid_a, ovf_a;
    logic [2:0]  count_a;

    logic        strobe_b, read_both;
    logic [31:0] data_b, bus_both, bus_fall;
    logic        valid_both, valid_fall, ovf_both, ovf_fall;
    logic [2:0]  count_both, count_fall;

    logic        strobe_c;
    logic [7:0]  data_w8;
    logic [31:0] data_w16, bus_w8;
    logic [15:0] bus_w16;
    logic        valid_w8, valid_w16, ovf_w8, ovf_w16;
    logic [2:0]  count_w8, count_w16;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    inport_fifo #(.EDGE_MODE(EDGE_RISE)) u_rise (
        .clock(clock), .clear_n(clear_n), .strobe(strobe_a), .External_Input(data_a),
        .read_en(read_a), .clr_ovf(clr_a), .BusMuxIn(bus_a), .valid(valid_a),
        .count(count_a), .overflow(ovf_a));

    inport_fifo #(.EDGE_MODE(EDGE_BOTH)) u_both (
        .clock(clock), .clear_n(clear_n), .strobe(strobe_b), .External_Input(data_b),
        .read_en(read_both), .clr_ovf(1'b0), .BusMuxIn(bus_both), .valid(valid_both),
        .count(count_both), .overflow(ovf_both));

    inport_fifo #(.EDGE_MODE(EDGE_FALL)) u_fall (
        .clock(clock), .clear_n(clear_n), .strobe(strobe_b), .External_Input(data_b),
        .read_en(1'b0), .clr_ovf(1'b0), .BusMuxIn(bus_fall), .valid(valid_fall),
        .count(count_fall), .overflow(ovf_fall));

    inport_fifo #(.DATA_WIDTH_IN(8), .DATA_WIDTH_OUT(32)) u_w8 (
        .clock(clock), .clear_n(clear_n), .strobe(strobe_c), .External_Input(data_w8),
        .read_en(1'b0), .clr_ovf(1'b0), .BusMuxIn(bus_w8), .valid(valid_w8),
        .count(count_w8), .overflow(ovf_w8));

    inport_fifo #(.DATA_WIDTH_IN(32), .DATA_WIDTH_OUT(16)) u_w16 (
        .clock(clock), .clear_n(clear_n), .strobe(strobe_c), .External_Input(data_w16),
        .read_en(1'b0), .clr_ovf(1'b0), .BusMuxIn(bus_w16), .valid(valid_w16),
        .count(count_w16), .overflow(ovf_w16));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One rise-mode capture of d on u_rise; the push lands on the third edge.
    task automatic pulse_a(input logic [31:0] d);
        data_a   = d;
        strobe_a = 1'b1;
        repeat (3) tick();
        strobe_a = 1'b0;
        repeat (2) tick();
    endtask

    task automatic pop_a();
        read_a = 1'b1;
        tick();
        read_a = 1'b0;
    endtask

    initial begin
        clear_n = 1'b0;
        strobe_a = 1'b1; read_a = 1'b0; clr_a = 1'b0; data_a = 32'h0;
        strobe_b = 1'b1; read_both = 1'b0; data_b = 32'h0;
        strobe_c = 1'b0; data_w8 = 8'h0; data_w16 = 32'h0;

        #12;
        chk("rst_valid", {31'd0, valid_a}, 32'd0);
        chk("rst_count", {29'd0, count_a}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf_a},   32'd0);
        chk("rst_bus",   bus_a,            32'd0);

        // Strobe held high across reset release.
        @(posedge clock); #1;
        clear_n = 1'b1;
        repeat (2) tick();
        chk("hold_rise_e2", {29'd0, count_a},    32'd0);
        chk("hold_both_e2", {29'd0, count_both}, 32'd0);
        tick();
        chk("hold_rise_e3", {29'd0, count_a},    32'd1);
        chk("hold_both_e3", {29'd0, count_both}, 32'd1);
        chk("hold_fall_e3", {29'd0, count_fall}, 32'd0);
        repeat (3) tick();
        chk("hold_rise_once", {29'd0, count_a},    32'd1);
        chk("hold_both_once", {29'd0, count_both}, 32'd1);
        chk("hold_fall_none", {29'd0, count_fall}, 32'd0);

        clear_n = 1'b0; strobe_a = 1'b0; strobe_b = 1'b0;
        tick();
        clear_n = 1'b1;
        repeat (2) tick();
        chk("rerst_rise", {29'd0, count_a},    32'd0);
        chk("rerst_both", {29'd0, count_both}, 32'd0);

        // Width adaptation.
        data_w8 = 8'hFF; data_w16 = 32'h1234_5678; strobe_c = 1'b1;
        repeat (3) tick();
        strobe_c = 1'b0;
        chk("w8_valid", {31'd0, valid_w8}, 32'd1);
        chk("w8_bus",   bus_w8,            32'h0000_00FF);
        chk("w16_bus",  {16'd0, bus_w16},  32'h0000_5678);
        repeat (3) tick();

        // Both/fall modes on one 10-cycle pulse.
        data_b = 32'h11; strobe_b = 1'b1;
        repeat (10) tick();
        data_b = 32'h22; strobe_b = 1'b0;
        repeat (4) tick();
        chk("both_count", {29'd0, count_both}, 32'd2);
        chk("both_head0", bus_both,            32'h11);
        chk("fall_count", {29'd0, count_fall}, 32'd1);
        chk("fall_head",  bus_fall,            32'h22);
        read_both = 1'b1; tick(); read_both = 1'b0;
        chk("both_head1", bus_both,            32'h22);
        chk("both_count1", {29'd0, count_both}, 32'd1);

        // Rise-mode latency and single pop.
        data_a = 32'hA5A5_0001; strobe_a = 1'b1;
        repeat (2) tick();
        chk("lat_k1_valid", {31'd0, valid_a}, 32'd0);
        tick();
        chk("lat_k2_valid", {31'd0, valid_a}, 32'd1);
        chk("lat_k2_bus",   bus_a,            32'hA5A5_0001);
        strobe_a = 1'b0;
        pop_a();
        chk("pop1_valid", {31'd0, valid_a}, 32'd0);
        chk("pop1_bus",   bus_a,            32'd0);
        repeat (2) tick();
        chk("rise_nofall", {29'd0, count_a}, 32'd0);

        // Overflow on the fifth capture, then drain in order.
        for (int i = 1; i <= 5; i++) pulse_a(32'(i));
        chk("ovf_count", {29'd0, count_a}, 32'd4);
        chk("ovf_flag",  {31'd0, ovf_a},   32'd1);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain", bus_a, 32'(i));
            pop_a();
        end
        chk("drain_valid", {31'd0, valid_a}, 32'd0);
        pop_a();
        chk("empty_pop_count", {29'd0, count_a}, 32'd0);
        chk("ovf_sticky", {31'd0, ovf_a}, 32'd1);
        clr_a = 1'b1; tick(); clr_a = 1'b0;
        chk("ovf_clear", {31'd0, ovf_a}, 32'd0);

        // Push and pop together while full.
        pulse_a(32'd10); pulse_a(32'd20); pulse_a(32'd30); pulse_a(32'd40);
        chk("full_count", {29'd0, count_a}, 32'd4);
        data_a = 32'd50; strobe_a = 1'b1;
        repeat (2) tick();
        read_a = 1'b1;
        tick();
        read_a = 1'b0; strobe_a = 1'b0;
        chk("pp_count", {29'd0, count_a}, 32'd4);
        chk("pp_ovf",   {31'd0, ovf_a},   32'd0);
        chk("pp_head",  bus_a,            32'd20);
        pop_a(); chk("pp_head30", bus_a, 32'd30);
        pop_a(); chk("pp_head40", bus_a, 32'd40);
        pop_a(); chk("pp_head50", bus_a, 32'd50);
        pop_a(); chk("pp_empty", {29'd0, count_a}, 32'd0);
        repeat (2) tick();

        // Asynchronous reset mid-stream, with an edge in flight.
        pulse_a(32'd7); pulse_a(32'd8); pulse_a(32'd9);
        chk("mid_count", {29'd0, count_a}, 32'd3);
        data_a = 32'hEE; strobe_a = 1'b1;
        tick();
        strobe_a = 1'b0; clear_n = 1'b0;
        #0.5;
        chk("arst_valid", {31'd0, valid_a}, 32'd0);
        chk("arst_count", {29'd0, count_a}, 32'd0);
        chk("arst_bus",   bus_a,            32'd0);
        #0.5;
        clear_n = 1'b1;
        repeat (4) tick();
        chk("arst_inflight", {29'd0, count_a}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inport_fifo.md
INPORT_FIFO -- requirements
Module: inport_fifo

Interface
REQ-001 Parameter DATA_WIDTH_IN, default 32, SHALL set the width of the external input data.
REQ-002 Parameter DATA_WIDTH_OUT, default 32, SHALL set the width of the bus-side data.
REQ-003 Parameter DEPTH, default 4, power of two and at least 2, SHALL set the number of FIFO entries.
REQ-004 Parameter SYNC_STAGES, default 2, at least 2, SHALL set the strobe synchronizer length.
REQ-005 Parameter EDGE_MODE, default EDGE_RISE, SHALL select the capture edge: EDGE_RISE, EDGE_FALL or EDGE_BOTH.
REQ-006 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-007 clear_n  in  1  reset, asynchronous and active-low.
REQ-008 strobe  in  1  external capture strobe, asynchronous to clock.
REQ-009 External_Input  in  DATA_WIDTH_IN  external data, held stable by the source from the strobe edge until capture.
REQ-010 read_en  in  1  bus-side pop request, synchronous to clock.
REQ-011 clr_ovf  in  1  synchronous clear of the overflow flag.
REQ-012 BusMuxIn  out  DATA_WIDTH_OUT  head-of-FIFO data.
REQ-013 valid  out  1  FIFO not empty.
REQ-014 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 overflow  out  1  sticky flag: a capture was dropped.

Function
REQ-016 strobe SHALL pass through SYNC_STAGES flops; the edge detector SHALL compare the synchronizer output with a one-cycle-delayed copy of it.
REQ-017 A detected edge matching EDGE_MODE SHALL push External_Input, sampled directly at that clock edge, into the FIFO tail.
REQ-018 Push latency: when strobe is first sampled high (rise mode) at edge k, count/valid SHALL update after edge k+SYNC_STAGES.
REQ-019 Width rule: if DATA_WIDTH_OUT > DATA_WIDTH_IN, BusMuxIn SHALL be zero-extended; otherwise it SHALL carry the low DATA_WIDTH_OUT bits of the entry.
REQ-020 BusMuxIn SHALL show the head entry combinationally from storage when valid=1, and SHALL be all-zero when valid=0.
REQ-021 read_en=1 with valid=1 SHALL pop the head at the clock edge; read_en on empty SHALL be ignored with no state change.
REQ-022 Push when full with no pop SHALL drop the data, leave the FIFO unchanged and set overflow.
REQ-023 Push and pop in the same cycle while full SHALL both take effect: count unchanged, no overflow.
REQ-024 Push and pop in the same cycle while empty SHALL perform the push only.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 clr_ovf=1 SHALL clear overflow at the next edge; if a dropped push occurs in the same cycle, set SHALL win.
REQ-027 In EDGE_BOTH mode, each synchronized transition SHALL produce exactly one push.

Reset
REQ-028 clear_n=0 SHALL immediately clear the synchronizer flops, the edge-history flop, pointers, count, overflow and storage to zero; outputs SHALL read valid=0, count=0, overflow=0, BusMuxIn=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries and any in-flight strobe edge.
REQ-030 If strobe is held high across reset release, rise and both modes SHALL capture exactly once after SYNC_STAGES+1 edges; fall mode SHALL not capture.

Structure
REQ-031 Package inport_pkg SHALL hold the EDGE_RISE=0, EDGE_FALL=1 and EDGE_BOTH=2 constants.
REQ-032 The synchronizer SHALL be a separate sub-module, sync_chain, parameterised by STAGES, with asynchronous active-low reset.
REQ-033 FIFO storage, pointers and flags SHALL live in inport_fifo.

Verification
Unless a scenario says otherwise, benches SHALL run with DEPTH=4, SYNC_STAGES=2, widths 32/32.
REQ-034 Rise mode, Input=0xA5A5_0001, strobe rising at edge k -> valid=1 and BusMuxIn=0xA5A5_0001 after edge k+2; one read_en pulse -> valid=0, BusMuxIn=0.
REQ-035 Five pulses with data 1..5 and no reads -> count=4, overflow=1; four pops return 1,2,3,4; clr_ovf -> overflow=0.
REQ-036 FIFO full, push and read_en in the same cycle -> count stays 4, overflow=0, head advances to the next entry.
REQ-037 EDGE_BOTH, one 10-cycle high pulse with data 0x11 then 0x22 -> two entries, 0x11 then 0x22; EDGE_FALL -> one entry, 0x22.
REQ-038 clear_n low for 1 ns mid-stream with 3 entries queued -> valid=0, count=0 and BusMuxIn=0 immediately, without a clock edge.
REQ-039 DATA_WIDTH_IN=8, DATA_WIDTH_OUT=32, Input=0xFF -> BusMuxIn=0x0000_00FF; widths 32/16 with Input=0x1234_5678 -> BusMuxIn=0x5678.
